// File: rtl/worksheet_col_encoder.sv
// worksheet_col_encoder
// Turns one arithmetic problem (up to HEIGHT-1 decimal operands plus an operator)
// into a column-major character stream. Each beat carries one HEIGHT-row column
// word. The stream ends with an all-space separator column. Operands are
// left-aligned and printed most-significant digit first. The operator sits in
// the bottom row of the first column.
module worksheet_col_encoder #(
  parameter int HEIGHT  = 5,
  parameter int MAX_DIG = 4,
  parameter int VAL_W   = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(HEIGHT-1)*VAL_W-1:0] in_vals,
  input  logic [2:0]                  in_cnt,
  input  logic [7:0]                  in_op,
  input  logic                        in_last,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic [HEIGHT*8-1:0]         col_data,
  output logic                        col_last,
  output logic [31:0]                 cols_sent,
  output logic                        err
);

  localparam int               ROWS    = HEIGHT - 1;
  localparam int               CW      = $clog2(MAX_DIG + 1);
  localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(10**MAX_DIG - 1);
  localparam logic [7:0]       SP      = 8'h20;
  localparam logic [7:0]       OP_ADD  = 8'h2B;
  localparam logic [7:0]       OP_MUL  = 8'h2A;

  typedef enum logic [1:0] {IDLE, CONV, EMIT, SEP} state_t;

  state_t               state;
  logic [VAL_W-1:0]     vals [ROWS];
  logic [MAX_DIG*4-1:0] digs [ROWS];
  logic [2:0]           cnt_q;
  logic [7:0]           op_q;
  logic                 last_q;
  logic [CW-1:0]        step;
  logic [CW-1:0]        col_idx;
  logic [CW-1:0]        ndig [ROWS];
  logic [CW-1:0]        width;
  logic [CW-1:0]        col_sel;
  logic [HEIGHT*8-1:0]  col_next;
  logic                 legal;

  // Low decimal digit of a working value.
  function automatic logic [3:0] dec_digit(input logic [VAL_W-1:0] v);
    return 4'(v % VAL_W'(10));
  endfunction

  // Working value with its low decimal digit removed.
  function automatic logic [VAL_W-1:0] dec_shift(input logic [VAL_W-1:0] v);
    return v / VAL_W'(10);
  endfunction

  // ASCII character for a decimal digit.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // A problem is accepted only when the operand count, the operator and every
  // used operand are renderable. Unused operand slots are don't-care.
  function automatic logic problem_legal(input logic [ROWS*VAL_W-1:0] v,
                                         input logic [2:0]            n,
                                         input logic [7:0]            op);
    logic ok;
    ok = (n != 3'd0) && (int'(n) <= ROWS) && (op == OP_ADD || op == OP_MUL);
    for (int k = 0; k < ROWS; k++) begin
      if (k < int'(n) && v[k*VAL_W +: VAL_W] > MAX_VAL) ok = 1'b0;
    end
    return ok;
  endfunction

  assign legal = problem_legal(in_vals, in_cnt, in_op);

  // Printed width of each operand, and the problem width over the used rows.
  // An all-zero operand still prints one "0".
  always_comb begin
    width = CW'(1);
    for (int k = 0; k < ROWS; k++) begin
      ndig[k] = CW'(1);
      for (int j = 0; j < MAX_DIG; j++) begin
        if (digs[k][j*4 +: 4] != 4'd0) ndig[k] = CW'(j + 1);
      end
      if (k < int'(cnt_q) && ndig[k] > width) width = ndig[k];
    end
  end

  // The column prepared for the next load. At the end of conversion this is
  // column 0. During EMIT it is the column after the one on the bus.
  assign col_sel = (state == EMIT) ? col_idx + CW'(1) : '0;

  // Build the column word for col_sel. Digits are stored LSD-first, so the
  // MSD-first, left-aligned character for column c is digit ndig-1-c.
  always_comb begin
    col_next = {HEIGHT{SP}};
    for (int k = 0; k < ROWS; k++) begin
      if (k < int'(cnt_q) && col_sel < ndig[k]) begin
        col_next[k*8 +: 8] =
          digit_char(digs[k][(int'(ndig[k]) - 1 - int'(col_sel))*4 +: 4]);
      end
    end
    if (col_sel == '0) col_next[ROWS*8 +: 8] = op_q;
  end

  // Control FSM. It also holds the digit datapath and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      col_valid <= 1'b0;
      col_data  <= {HEIGHT{SP}};
      col_last  <= 1'b0;
      cols_sent <= '0;
      err       <= 1'b0;
      step      <= '0;
      col_idx   <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      last_q    <= 1'b0;
      for (int k = 0; k < ROWS; k++) begin
        vals[k] <= '0;
        digs[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (!legal) begin
              err <= 1'b1;
            end else begin
              for (int k = 0; k < ROWS; k++) begin
                vals[k] <= (k < int'(in_cnt)) ? in_vals[k*VAL_W +: VAL_W] : '0;
              end
              cnt_q    <= in_cnt;
              op_q     <= in_op;
              last_q   <= in_last;
              step     <= '0;
              in_ready <= 1'b0;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          if (step != CW'(MAX_DIG)) begin
            for (int k = 0; k < ROWS; k++) begin
              digs[k][int'(step)*4 +: 4] <= dec_digit(vals[k]);
              vals[k]                    <= dec_shift(vals[k]);
            end
            step <= step + CW'(1);
          end else begin
            col_data  <= col_next;
            col_valid <= 1'b1;
            col_last  <= 1'b0;
            col_idx   <= '0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (col_ready) begin
            cols_sent <= cols_sent + 32'd1;
            if (col_idx == width - CW'(1)) begin
              col_data <= {HEIGHT{SP}};
              col_last <= last_q;
              state    <= SEP;
            end else begin
              col_idx  <= col_idx + CW'(1);
              col_data <= col_next;
            end
          end
        end
        SEP: begin
          if (col_ready) begin
            cols_sent <= cols_sent + 32'd1;
            col_valid <= 1'b0;
            col_last  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_worksheet_col_encoder.sv
// Testbench for worksheet_col_encoder (HEIGHT=5, MAX_DIG=4, VAL_W=14).
// The main part is a table of directed problems with hand-computed columns.
// Hand-written sequences cover backpressure, reset during EMIT, and a randomized
// round trip through a column-solver model.
module tb_worksheet_col_encoder;

  localparam logic [39:0] SPACES = {5{8'h20}};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_vals;
  logic [2:0]  in_cnt;
  logic [7:0]  in_op;
  logic        in_last;
  logic        col_valid;
  logic        col_ready;
  logic [39:0] col_data;
  logic        col_last;
  logic [31:0] cols_sent;
  logic        err;

  always #5 clk = ~clk;

  worksheet_col_encoder #(.HEIGHT(5), .MAX_DIG(4), .VAL_W(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vals(in_vals), .in_cnt(in_cnt), .in_op(in_op), .in_last(in_last),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .col_last(col_last), .cols_sent(cols_sent), .err(err)
  );

  typedef struct packed {
    logic [3:0][13:0] vals;
    logic [2:0]       cnt;
    logic [7:0]       op;
    logic             last;
    logic             illegal;
    logic [2:0]       ncols;
    logic [3:0][39:0] cols;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [39:0] got_data [8];
  logic        got_last [8];
  int          got_n;
  int          lat;
  logic [31:0] exp_sent;
  logic        exp_err;
  vec_t        vecs [10];
  vec_t        v;
  logic        saw;

  // round-trip state
  logic [55:0]     rt_vals;
  int              rt_cnt;
  logic [7:0]      rt_op;
  logic            rt_lastp;
  longint unsigned rt_ref, rt_got, rt_ref_total, rt_got_total;
  longint unsigned rv [4];
  logic            used [4];
  logic [7:0]      opc;
  logic [7:0]      ch;
  int              rt_w, rt_beats, rt_guard, rt_d, rt_lo, rt_hi, rt_v;
  logic            rt_done, char_bad, last_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [13:0] a, input logic [13:0] b,
                              input logic [13:0] c, input logic [13:0] d,
                              input logic [2:0] n, input logic [7:0] op,
                              input logic last, input logic ill, input logic [2:0] nc,
                              input logic [39:0] x0, input logic [39:0] x1,
                              input logic [39:0] x2, input logic [39:0] x3);
    vec_t r;
    r.vals[0] = a; r.vals[1] = b; r.vals[2] = c; r.vals[3] = d;
    r.cnt = n; r.op = op; r.last = last; r.illegal = ill; r.ncols = nc;
    r.cols[0] = x0; r.cols[1] = x1; r.cols[2] = x2; r.cols[3] = x3;
    return r;
  endfunction

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Offer one problem; returns on the negedge after the accepting edge.
  task automatic send(input logic [55:0] vals, input logic [2:0] n,
                      input logic [7:0] op, input logic last);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    in_vals  = vals;
    in_cnt   = n;
    in_op    = op;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until col_valid rises (bounded).
  task automatic wait_valid();
    lat = 0;
    while (!col_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Accept beats with col_ready held high until the separator has gone.
  task automatic take_beats();
    int   guard;
    logic done;
    guard = 0;
    done  = 1'b0;
    got_n = 0;
    for (int i = 0; i < 8; i++) begin
      got_data[i] = '0;
      got_last[i] = 1'b0;
    end
    col_ready = 1'b1;
    while (!done && guard < 40) begin
      if (col_valid && got_n < 8) begin
        got_data[got_n] = col_data;
        got_last[got_n] = col_last;
        got_n++;
        if (col_data == SPACES) done = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    chk("beats_done", 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vals = '0; in_cnt = '0; in_op = '0;
    in_last = 1'b0; col_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_col_valid", 64'(col_valid), 64'd0);
    chk("rst_col_data", 64'(col_data), 64'(SPACES));
    chk("rst_col_last", 64'(col_last), 64'd0);
    chk("rst_cols_sent", 64'(cols_sent), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    vecs[0] = mk(14'd123, 14'd45, 14'd6, 14'd0, 3'd3, 8'h2A, 1'b0, 1'b0, 3'd3,
                 40'h2A20363431, 40'h2020203532, 40'h2020202033, 40'h0);
    vecs[1] = mk(14'd0, 14'd0, 14'd0, 14'd0, 3'd1, 8'h2B, 1'b1, 1'b0, 3'd1,
                 40'h2B20202030, 40'h0, 40'h0, 40'h0);
    vecs[2] = mk(14'd9999, 14'd1, 14'd0, 14'd42, 3'd4, 8'h2B, 1'b0, 1'b0, 3'd4,
                 40'h2B34303139, 40'h2032202039, 40'h2020202039, 40'h2020202039);
    vecs[3] = mk(14'd1000, 14'd7, 14'd0, 14'd0, 3'd2, 8'h2A, 1'b0, 1'b0, 3'd4,
                 40'h2A20203731, 40'h2020202030, 40'h2020202030, 40'h2020202030);
    vecs[4] = mk(14'd1, 14'd0, 14'd0, 14'd0, 3'd1, 8'h2D, 1'b0, 1'b1, 3'd0,
                 40'h0, 40'h0, 40'h0, 40'h0);
    vecs[5] = mk(14'd50, 14'd0, 14'd305, 14'd12345, 3'd3, 8'h2B, 1'b0, 1'b0, 3'd3,
                 40'h2B20333035, 40'h2020302030, 40'h2020352020, 40'h0);
    vecs[6] = mk(14'd5, 14'd0, 14'd0, 14'd0, 3'd0, 8'h2B, 1'b0, 1'b1, 3'd0,
                 40'h0, 40'h0, 40'h0, 40'h0);
    vecs[7] = mk(14'd10000, 14'd0, 14'd0, 14'd0, 3'd1, 8'h2B, 1'b0, 1'b1, 3'd0,
                 40'h0, 40'h0, 40'h0, 40'h0);
    vecs[8] = mk(14'd1, 14'd2, 14'd3, 14'd4, 3'd5, 8'h2A, 1'b0, 1'b1, 3'd0,
                 40'h0, 40'h0, 40'h0, 40'h0);
    vecs[9] = mk(14'd7, 14'd0, 14'd0, 14'd0, 3'd1, 8'h2A, 1'b0, 1'b0, 3'd1,
                 40'h2A20202037, 40'h0, 40'h0, 40'h0);

    exp_sent = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      send(v.vals, v.cnt, v.op, v.last);
      if (v.illegal) begin
        exp_err = 1'b1;
        chk("ill_in_ready", 64'(in_ready), 64'd1);
        chk("ill_err", 64'(err), 64'd1);
        saw = 1'b0;
        repeat (8) begin
          @(negedge clk);
          if (col_valid) saw = 1'b1;
        end
        chk("ill_no_col", 64'(saw), 64'd0);
      end else begin
        wait_valid();
        chk("lat", 64'(lat), 64'd5);
        take_beats();
        chk("nbeats", 64'(got_n), 64'(int'(v.ncols) + 1));
        for (int j = 0; j < int'(v.ncols); j++) begin
          chk("col", 64'(got_data[j]), 64'(v.cols[j]));
          chk("col_last_data", 64'(got_last[j]), 64'd0);
        end
        chk("sep", 64'(got_data[v.ncols]), 64'(SPACES));
        chk("sep_last", 64'(got_last[v.ncols]), 64'(v.last));
        exp_sent = exp_sent + 32'(int'(v.ncols) + 1);
        chk("cols_sent", 64'(cols_sent), 64'(exp_sent));
        chk("err_sticky", 64'(err), 64'(exp_err));
      end
    end

    // Backpressure: stall 7 cycles on column 1.
    col_ready = 1'b0;
    send({14'd0, 14'd6, 14'd45, 14'd123}, 3'd3, 8'h2A, 1'b0);
    wait_valid();
    chk("stall_lat", 64'(lat), 64'd5);
    chk("stall_c0", 64'(col_data), 64'h2A20363431);
    col_ready = 1'b1;
    @(negedge clk);
    col_ready = 1'b0;
    chk("stall_c1", 64'(col_data), 64'h2020203532);
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      chk("stall_hold", 64'(col_data), 64'h2020203532);
      chk("stall_vld", 64'(col_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    take_beats();
    chk("stall_n", 64'(got_n), 64'd3);
    chk("stall_b0", 64'(got_data[0]), 64'h2020203532);
    chk("stall_b1", 64'(got_data[1]), 64'h2020202033);
    chk("stall_b2", 64'(got_data[2]), 64'(SPACES));
    exp_sent = exp_sent + 32'd4;
    chk("stall_cols_sent", 64'(cols_sent), 64'(exp_sent));

    // Reset while column 1 is on the bus.
    col_ready = 1'b0;
    send({14'd0, 14'd6, 14'd45, 14'd123}, 3'd3, 8'h2A, 1'b0);
    wait_valid();
    col_ready = 1'b1;
    @(negedge clk);
    col_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_col_valid", 64'(col_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_cols_sent", 64'(cols_sent), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_col_data", 64'(col_data), 64'(SPACES));
    exp_sent = '0;
    send({14'd0, 14'd0, 14'd0, 14'd0}, 3'd1, 8'h2B, 1'b1);
    wait_valid();
    chk("post_rst_lat", 64'(lat), 64'd5);
    take_beats();
    chk("post_rst_n", 64'(got_n), 64'd2);
    chk("post_rst_c0", 64'(got_data[0]), 64'h2B20202030);
    chk("post_rst_l0", 64'(got_last[0]), 64'd0);
    chk("post_rst_sep", 64'(got_data[1]), 64'(SPACES));
    chk("post_rst_l1", 64'(got_last[1]), 64'd1);
    exp_sent = exp_sent + 32'd2;
    chk("post_rst_cols_sent", 64'(cols_sent), 64'(exp_sent));

    // Round trip: random legal problems, random backpressure, solver model.
    rt_ref_total = 0;
    rt_got_total = 0;
    char_bad = 1'b0;
    last_bad = 1'b0;
    for (int p = 0; p < 50; p++) begin
      rt_cnt   = int'($urandom_range(1, 4));
      rt_op    = ($urandom_range(0, 1) == 1) ? 8'h2A : 8'h2B;
      rt_lastp = (p == 49);
      rt_ref   = (rt_op == 8'h2A) ? 1 : 0;
      rt_w     = 1;
      for (int k = 0; k < 4; k++) begin
        if (k < rt_cnt) begin
          rt_d  = int'($urandom_range(1, 4));
          rt_lo = (rt_d == 1) ? 0 : pow10(rt_d - 1);
          rt_hi = pow10(rt_d) - 1;
          rt_v  = int'($urandom_range(rt_hi, rt_lo));
          rt_vals[k*14 +: 14] = 14'(rt_v);
          rt_ref = (rt_op == 8'h2A) ? rt_ref * longint'(rt_v) : rt_ref + longint'(rt_v);
          if (rt_d > rt_w) rt_w = rt_d;
        end else begin
          rt_vals[k*14 +: 14] = 14'($urandom_range(0, 16383));
        end
      end
      rt_ref_total = rt_ref_total + rt_ref;
      send(rt_vals, 3'(rt_cnt), rt_op, rt_lastp);

      for (int k = 0; k < 4; k++) begin
        rv[k]   = 0;
        used[k] = 1'b0;
      end
      opc      = 8'h00;
      rt_beats = 0;
      rt_guard = 0;
      rt_done  = 1'b0;
      while (!rt_done && rt_guard < 400) begin
        col_ready = ($urandom_range(0, 3) != 0);
        if (col_valid && col_ready) begin
          rt_beats++;
          if (rt_beats == 1) opc = col_data[39:32];
          for (int k = 0; k < 4; k++) begin
            ch = col_data[k*8 +: 8];
            if (ch >= 8'h30 && ch <= 8'h39) begin
              rv[k]   = rv[k] * 10 + longint'(ch - 8'h30);
              used[k] = 1'b1;
            end else if (ch != 8'h20) begin
              char_bad = 1'b1;
            end
          end
          ch = col_data[39:32];
          if (ch != 8'h20 && ch != 8'h2A && ch != 8'h2B) char_bad = 1'b1;
          if (col_data == SPACES) begin
            rt_done = 1'b1;
            if (col_last !== rt_lastp) last_bad = 1'b1;
          end else if (col_last !== 1'b0) begin
            last_bad = 1'b1;
          end
        end
        @(negedge clk);
        rt_guard++;
      end
      chk("rt_done", 64'(rt_done), 64'd1);
      rt_got = (opc == 8'h2A) ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
        if (used[k]) rt_got = (opc == 8'h2A) ? rt_got * rv[k] : rt_got + rv[k];
      end
      rt_got_total = rt_got_total + rt_got;
      chk("rt_result", 64'(rt_got), 64'(rt_ref));
      chk("rt_beats", 64'(rt_beats), 64'(rt_w + 1));
      exp_sent = exp_sent + 32'(rt_w + 1);
    end
    chk("rt_total", 64'(rt_got_total), 64'(rt_ref_total));
    chk("rt_cols_sent", 64'(cols_sent), 64'(exp_sent));
    chk("rt_charset", 64'(char_bad), 64'd0);
    chk("rt_col_last", 64'(last_bad), 64'd0);
    chk("rt_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
